ysyx_22040237_idu_stage: RTL and testbench
==========================================

Name: ysyx_22040237_idu_stage

Overview:
Pipelined, parametrised successor to the single-cycle decoder. Sits between IFU and EXU with valid/ready handshakes on both sides. Decodes the full RV64I integer subset plus EBREAK, forms ALU and jump operands, and carries the decoded bundles in a small output queue so the EXU can stall without losing instructions. Registered output; supports pipeline flush.

Parameters:
XLEN, 64, datapath width of operands and register data
PC_W, 32, PC width; zero-extended to XLEN for operands
DEPTH, 2, output queue entries (power of two, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous flush; drops queue and current input
in_valid  in  1  IFU has an instruction
in_ready  out  1  stage can accept this cycle
in_pc  in  PC_W  instruction PC
in_inst  in  32  instruction word
rs1_addr  out  5  combinational regfile read address (in_inst[19:15])
rs2_addr  out  5  combinational regfile read address (in_inst[24:20])
rs1_data  in  XLEN  regfile read data, same cycle
rs2_data  in  XLEN  regfile read data, same cycle
out_valid  out  1  queue head is valid
out_ready  in  1  EXU accepts head
out_alu_op  out  8  ALU operation code
out_op1  out  XLEN  ALU operand 1
out_op2  out  XLEN  ALU operand 2
out_jmp_op1  out  PC_W  jump/branch target base
out_jmp_op2  out  PC_W  jump/branch target offset
out_jump  out  1  unconditional jump (JAL/JALR)
out_branch  out  1  conditional branch; out_func3 selects condition
out_func3  out  3  raw func3 (branch cond, load/store size)
out_mem_rd  out  1  load
out_mem_wr  out  1  store; store data in out_store_data
out_store_data  out  XLEN  rs2_data captured for stores
out_word  out  1  *W op: EXU sign-extends result bits [31:0]
out_rd_we  out  1  destination write enable (forced 0 when rd==0)
out_rd  out  5  destination register
out_ebreak  out  1  inst == 32'h00100073
out_invalid  out  1  unrecognised instruction

Behaviour:
- Reset (rst_n low, async): queue empty; out_valid=0, in_ready=0; all out_* fields 0. in_ready rises the first edge after reset release.
- Accept: in_valid & in_ready at a rising edge. Decode is combinational from in_inst/in_pc/rs*_data; the full bundle is written to the queue tail on that edge. Latency 1: into an empty queue, out_valid=1 the following cycle.
- in_ready = (count < DEPTH) & ~flush; registered count only, no same-cycle pass-through when full.
- Pop: out_valid & out_ready at an edge. Simultaneous push and pop: count unchanged, order preserved. Pointers wrap modulo DEPTH.
- out_* reflects the head entry; holds stable while out_valid & ~out_ready.
- flush: next edge sets count=0, drops any simultaneous push; out_valid=0 the following cycle.
- Immediates are sign-extended to XLEN: I {inst[31:20]}, S {inst[31:25],inst[11:7]}, B {inst[31],inst[7],inst[30:25],inst[11:8],0}, U {inst[31:12],12'b0}, J {inst[31],inst[19:12],inst[20],inst[30:21],0}.
- Operands: OP/OP-32 op1=rs1,op2=rs2; OP-IMM(-32)/LOAD/STORE op1=rs1,op2=immI/S (ALU ADD computes address); LUI op1=0,op2=immU; AUIPC op1=pc,op2=immU; JAL op1=pc,op2=4,jmp=(pc,immJ); JALR op1=pc,op2=4,jmp=(rs1[PC_W-1:0],immI); BRANCH op1=rs1,op2=rs2,alu SUB,jmp=(pc,immB), rd_we=0.
- ALU codes: NOP 00, ADD 01, SUB 02, AND 03, OR 04, XOR 05, SLL 06, SRL 07, SRA 08, SLT 09, SLTU 0A. Bit 30 selects SUB/SRA; shift amount inst[25:20] (inst[24:20] for *W).
- Invalid (opcode, func3 or func7 not defined in RV64I; inst==0 included): out_invalid=1, all enables 0, alu NOP. Invalid entries still flow through the queue.

Decomposition:
- Package ysyx_22040237_defs: ALU op codes, opcode constants, instruction-format enum, decoded-bundle field widths.
- Sub-module ysyx_22040237_idu_dec: pure combinational decoder producing one bundle; top holds the queue, pointers, count and handshakes.

Test Plan:
- addi x1,x0,5 (0x00500093), rs1_data=0 -> next cycle out_valid=1, alu 01, op1=0, op2=5, rd=1, rd_we=1.
- lui x2,0x12345 (0x12345137) then jal x1,+8 (0x008000EF) at pc 0x80000004 -> op2=0x12345000; then op1=0x80000004, op2=4, jmp=(0x80000004,8), out_jump=1.
- out_ready=0, push 3 back-to-back -> in_ready low after 2 accepts; out_ready=1 -> entries emerge in order; simultaneous push/pop keeps count.
- 0xFFFFFFFF and 0x00000000 -> out_invalid=1, rd_we=0; 0x00100073 -> out_ebreak=1.
- Queue holding 2 entries, flush with in_valid=1 -> out_valid=0 next cycle, input dropped, nothing emerges later.
- rst_n low mid-stream with out_valid=1 -> out_valid=0 immediately (async); after release the first accepted instruction emerges correctly.

Source files
------------

// File: rtl/ysyx_22040237_defs.sv
// Shared decode definitions for the IDU stage: ALU codes, RV64I opcodes,
// immediate formats and the control half of a decoded bundle.
package ysyx_22040237_defs;

  localparam int ALU_OP_W = 8;
  localparam int FUNC3_W  = 3;
  localparam int REG_W    = 5;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_NOP  = 8'h00, ALU_ADD = 8'h01, ALU_SUB = 8'h02, ALU_AND = 8'h03,
    ALU_OR   = 8'h04, ALU_XOR = 8'h05, ALU_SLL = 8'h06, ALU_SRL = 8'h07,
    ALU_SRA  = 8'h08, ALU_SLT = 8'h09, ALU_SLTU = 8'h0A
  } alu_op_e;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  localparam logic [6:0]  F7_BASE     = 7'b0000000;
  localparam logic [6:0]  F7_ALT      = 7'b0100000;
  localparam logic [31:0] INST_EBREAK = 32'h00100073;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X} fmt_e;

  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    logic                jump;
    logic                branch;
    logic [FUNC3_W-1:0]  func3;
    logic                mem_rd;
    logic                mem_wr;
    logic                word;
    logic                rd_we;
    logic [REG_W-1:0]    rd;
    logic                ebreak;
    logic                invalid;
  } ctrl_t;

  // alt is inst[30] where it distinguishes SUB/SRA, else 0
  function automatic alu_op_e f3_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22040237_idu_stage_dec.sv
// Pure combinational RV64I + EBREAK decoder: one instruction in, one bundle out.
module ysyx_22040237_idu_dec
  import ysyx_22040237_defs::*;
#(
  parameter int XLEN = 64,
  parameter int PC_W = 32
) (
  input  logic [31:0]     i_inst,
  input  logic [PC_W-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output ctrl_t           o_ctrl,
  output logic [XLEN-1:0] o_op1,
  output logic [XLEN-1:0] o_op2,
  output logic [XLEN-1:0] o_sdata,
  output logic [PC_W-1:0] o_jop1,
  output logic [PC_W-1:0] o_jop2
);
  logic [6:0]      w_opc, w_f7;
  logic [2:0]      w_f3;
  logic [4:0]      w_rd;
  fmt_e            w_fmt;
  logic [XLEN-1:0] w_imm, w_pc_x;
  logic            w_ok, w_we;

  assign w_opc  = i_inst[6:0];
  assign w_rd   = i_inst[11:7];
  assign w_f3   = i_inst[14:12];
  assign w_f7   = i_inst[31:25];
  assign w_pc_x = {{(XLEN-PC_W){1'b0}}, i_pc};

  always_comb begin
    w_fmt = FMT_X;
    case (w_opc)
      OPC_OP, OPC_OP32:                               w_fmt = FMT_R;
      OPC_OPIMM, OPC_OPIMM32, OPC_LOAD, OPC_JALR:     w_fmt = FMT_I;
      OPC_STORE:                                      w_fmt = FMT_S;
      OPC_BRANCH:                                     w_fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:                             w_fmt = FMT_U;
      OPC_JAL:                                        w_fmt = FMT_J;
      default:                                        w_fmt = FMT_X;
    endcase
  end

  always_comb begin
    case (w_fmt)
      FMT_I:   w_imm = {{(XLEN-12){i_inst[31]}}, i_inst[31:20]};
      FMT_S:   w_imm = {{(XLEN-12){i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      FMT_B:   w_imm = {{(XLEN-13){i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
      FMT_U:   w_imm = {{(XLEN-32){i_inst[31]}}, i_inst[31:12], 12'b0};
      FMT_J:   w_imm = {{(XLEN-21){i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
      default: w_imm = '0;
    endcase
  end

  always_comb begin
    w_ok          = 1'b0;
    w_we          = 1'b0;
    o_ctrl        = '0;
    o_ctrl.func3  = w_f3;
    o_ctrl.rd     = w_rd;
    o_ctrl.alu_op = ALU_NOP;
    o_op1         = '0;
    o_op2         = '0;
    o_sdata       = '0;
    o_jop1        = '0;
    o_jop2        = '0;
    case (w_opc)
      OPC_OP, OPC_OP32: begin
        w_we = 1'b1; o_op1 = i_rs1; o_op2 = i_rs2;
        o_ctrl.word   = (w_opc == OPC_OP32);
        o_ctrl.alu_op = f3_alu(w_f3, i_inst[30]);
        if (w_opc == OPC_OP)
          w_ok = (w_f7 == F7_BASE) || (w_f7 == F7_ALT && (w_f3 == 3'b000 || w_f3 == 3'b101));
        else
          w_ok = (w_f7 == F7_BASE && (w_f3 == 3'b000 || w_f3 == 3'b001 || w_f3 == 3'b101)) ||
                 (w_f7 == F7_ALT  && (w_f3 == 3'b000 || w_f3 == 3'b101));
      end
      OPC_OPIMM: begin
        w_we = 1'b1; o_op1 = i_rs1; o_op2 = w_imm;
        o_ctrl.alu_op = f3_alu(w_f3, (w_f3 == 3'b101) & i_inst[30]);
        case (w_f3)
          3'b001: begin w_ok = (i_inst[31:26] == 6'b000000); o_op2 = XLEN'(i_inst[25:20]); end
          3'b101: begin
            w_ok  = (i_inst[31:26] == 6'b000000) || (i_inst[31:26] == 6'b010000);
            o_op2 = XLEN'(i_inst[25:20]);
          end
          default: w_ok = 1'b1;
        endcase
      end
      OPC_OPIMM32: begin
        w_we = 1'b1; o_op1 = i_rs1; o_op2 = w_imm; o_ctrl.word = 1'b1;
        o_ctrl.alu_op = f3_alu(w_f3, (w_f3 == 3'b101) & i_inst[30]);
        case (w_f3)
          3'b000:  w_ok = 1'b1;
          3'b001:  begin w_ok = (w_f7 == F7_BASE); o_op2 = XLEN'(i_inst[24:20]); end
          3'b101:  begin w_ok = (w_f7 == F7_BASE) || (w_f7 == F7_ALT); o_op2 = XLEN'(i_inst[24:20]); end
          default: w_ok = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        w_ok = (w_f3 != 3'b111); w_we = 1'b1; o_ctrl.mem_rd = 1'b1;
        o_ctrl.alu_op = ALU_ADD; o_op1 = i_rs1; o_op2 = w_imm;
      end
      OPC_STORE: begin
        w_ok = ~w_f3[2]; o_ctrl.mem_wr = 1'b1; o_ctrl.alu_op = ALU_ADD;
        o_op1 = i_rs1; o_op2 = w_imm; o_sdata = i_rs2;
      end
      OPC_BRANCH: begin
        w_ok = (w_f3[2:1] != 2'b01); o_ctrl.branch = 1'b1; o_ctrl.alu_op = ALU_SUB;
        o_op1 = i_rs1; o_op2 = i_rs2; o_jop1 = i_pc; o_jop2 = w_imm[PC_W-1:0];
      end
      OPC_LUI:   begin w_ok = 1'b1; w_we = 1'b1; o_ctrl.alu_op = ALU_ADD; o_op2 = w_imm; end
      OPC_AUIPC: begin w_ok = 1'b1; w_we = 1'b1; o_ctrl.alu_op = ALU_ADD; o_op1 = w_pc_x; o_op2 = w_imm; end
      OPC_JAL: begin
        w_ok = 1'b1; w_we = 1'b1; o_ctrl.jump = 1'b1; o_ctrl.alu_op = ALU_ADD;
        o_op1 = w_pc_x; o_op2 = XLEN'(4); o_jop1 = i_pc; o_jop2 = w_imm[PC_W-1:0];
      end
      OPC_JALR: begin
        w_ok = (w_f3 == 3'b000); w_we = 1'b1; o_ctrl.jump = 1'b1; o_ctrl.alu_op = ALU_ADD;
        o_op1 = w_pc_x; o_op2 = XLEN'(4); o_jop1 = i_rs1[PC_W-1:0]; o_jop2 = w_imm[PC_W-1:0];
      end
      OPC_SYSTEM: begin w_ok = (i_inst == INST_EBREAK); o_ctrl.ebreak = w_ok; end
      default:    w_ok = 1'b0;
    endcase
    o_ctrl.rd_we = w_we & w_ok & (w_rd != 5'd0);
    // anything unrecognised becomes an inert bubble tagged invalid
    if (!w_ok) begin
      o_ctrl.alu_op = ALU_NOP; o_ctrl.jump = 1'b0; o_ctrl.branch = 1'b0;
      o_ctrl.mem_rd = 1'b0;    o_ctrl.mem_wr = 1'b0; o_ctrl.word = 1'b0;
      o_ctrl.ebreak = 1'b0;    o_ctrl.invalid = 1'b1;
      o_op1 = '0; o_op2 = '0; o_sdata = '0; o_jop1 = '0; o_jop2 = '0;
    end
  end

endmodule

// File: rtl/ysyx_22040237_idu_stage.sv
// IDU pipeline stage: decodes on accept and buffers bundles in a small FIFO
// so the EXU can stall; outputs come straight from the FIFO head register.
module ysyx_22040237_idu_stage
  import ysyx_22040237_defs::*;
#(
  parameter int XLEN  = 64,
  parameter int PC_W  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC_W-1:0] in_pc,
  input  logic [31:0]     in_inst,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_alu_op,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [PC_W-1:0] out_jmp_op1,
  output logic [PC_W-1:0] out_jmp_op2,
  output logic            out_jump,
  output logic            out_branch,
  output logic [2:0]      out_func3,
  output logic            out_mem_rd,
  output logic            out_mem_wr,
  output logic [XLEN-1:0] out_store_data,
  output logic            out_word,
  output logic            out_rd_we,
  output logic [4:0]      out_rd,
  output logic            out_ebreak,
  output logic            out_invalid
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  ctrl_t           w_ctrl;
  logic [XLEN-1:0] w_op1, w_op2, w_sdata;
  logic [PC_W-1:0] w_jop1, w_jop2;
  logic            w_push, w_pop;

  ctrl_t           r_ctrl  [DEPTH];
  logic [XLEN-1:0] r_op1   [DEPTH];
  logic [XLEN-1:0] r_op2   [DEPTH];
  logic [XLEN-1:0] r_sdata [DEPTH];
  logic [PC_W-1:0] r_jop1  [DEPTH];
  logic [PC_W-1:0] r_jop2  [DEPTH];
  logic [PTR_W-1:0] r_wp, r_rp;
  logic [CNT_W-1:0] r_cnt;
  logic             r_live;

  ysyx_22040237_idu_dec #(.XLEN(XLEN), .PC_W(PC_W)) u_dec (
    .i_inst(in_inst), .i_pc(in_pc), .i_rs1(rs1_data), .i_rs2(rs2_data),
    .o_ctrl(w_ctrl), .o_op1(w_op1), .o_op2(w_op2), .o_sdata(w_sdata),
    .o_jop1(w_jop1), .o_jop2(w_jop2)
  );

  assign rs1_addr  = in_inst[19:15];
  assign rs2_addr  = in_inst[24:20];
  // r_live keeps in_ready low until the first edge after reset release
  assign in_ready  = r_live & (r_cnt < CNT_W'(DEPTH)) & ~flush;
  assign out_valid = (r_cnt != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp <= '0; r_rp <= '0; r_cnt <= '0; r_live <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (flush) begin
        r_wp <= '0; r_rp <= '0; r_cnt <= '0;
      end else begin
        if (w_push) r_wp <= r_wp + PTR_W'(1);
        if (w_pop)  r_rp <= r_rp + PTR_W'(1);
        case ({w_push, w_pop})
          2'b10:   r_cnt <= r_cnt + CNT_W'(1);
          2'b01:   r_cnt <= r_cnt - CNT_W'(1);
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_ctrl[k] <= '0; r_op1[k] <= '0; r_op2[k] <= '0;
        r_sdata[k] <= '0; r_jop1[k] <= '0; r_jop2[k] <= '0;
      end
    end else if (w_push) begin
      r_ctrl[r_wp]  <= w_ctrl;
      r_op1[r_wp]   <= w_op1;
      r_op2[r_wp]   <= w_op2;
      r_sdata[r_wp] <= w_sdata;
      r_jop1[r_wp]  <= w_jop1;
      r_jop2[r_wp]  <= w_jop2;
    end
  end

  assign out_alu_op     = r_ctrl[r_rp].alu_op;
  assign out_jump       = r_ctrl[r_rp].jump;
  assign out_branch     = r_ctrl[r_rp].branch;
  assign out_func3      = r_ctrl[r_rp].func3;
  assign out_mem_rd     = r_ctrl[r_rp].mem_rd;
  assign out_mem_wr     = r_ctrl[r_rp].mem_wr;
  assign out_word       = r_ctrl[r_rp].word;
  assign out_rd_we      = r_ctrl[r_rp].rd_we;
  assign out_rd         = r_ctrl[r_rp].rd;
  assign out_ebreak     = r_ctrl[r_rp].ebreak;
  assign out_invalid    = r_ctrl[r_rp].invalid;
  assign out_op1        = r_op1[r_rp];
  assign out_op2        = r_op2[r_rp];
  assign out_store_data = r_sdata[r_rp];
  assign out_jmp_op1    = r_jop1[r_rp];
  assign out_jmp_op2    = r_jop2[r_rp];

endmodule

// File: tb/tb_ysyx_22040237_idu_stage.sv
// Bench for the IDU stage: directed test-plan steps, then randomized traffic
// checked against a mask/match instruction table and a queue model.
module tb_ysyx_22040237_idu_stage;
  localparam int XLEN = 64, PC_W = 32, DEPTH = 2;
  localparam int C_R = 0, C_RW = 1, C_I = 2, C_IW = 3, C_SH = 4, C_SHW = 5, C_LD = 6,
                 C_ST = 7, C_BR = 8, C_LUI = 9, C_AUIPC = 10, C_JAL = 11, C_JALR = 12, C_EBRK = 13;

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [31:0] in_pc = '0, in_inst = '0;
  logic [63:0] rs1_data = '0, rs2_data = '0;
  logic [4:0]  rs1_addr, rs2_addr, out_rd;
  logic [7:0]  out_alu_op;
  logic [63:0] out_op1, out_op2, out_store_data;
  logic [31:0] out_jmp_op1, out_jmp_op2;
  logic [2:0]  out_func3;
  logic out_jump, out_branch, out_mem_rd, out_mem_wr, out_word, out_rd_we, out_ebreak, out_invalid;

  always #5 clk = ~clk;

  ysyx_22040237_idu_stage #(.XLEN(XLEN), .PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_op(out_alu_op), .out_op1(out_op1), .out_op2(out_op2),
    .out_jmp_op1(out_jmp_op1), .out_jmp_op2(out_jmp_op2), .out_jump(out_jump),
    .out_branch(out_branch), .out_func3(out_func3), .out_mem_rd(out_mem_rd),
    .out_mem_wr(out_mem_wr), .out_store_data(out_store_data), .out_word(out_word),
    .out_rd_we(out_rd_we), .out_rd(out_rd), .out_ebreak(out_ebreak), .out_invalid(out_invalid)
  );

  typedef struct packed {
    logic [7:0] alu; logic [63:0] op1, op2; logic [31:0] j1, j2;
    logic jump, branch; logic [2:0] f3; logic mrd, mwr; logic [63:0] sd;
    logic word, we; logic [4:0] rd; logic ebreak, invalid;
  } exp_t;

  logic [31:0] pm[$], pv[$];
  int          pcls[$];
  logic [7:0]  palu[$];
  exp_t        q[$];
  logic        rdy_en = 1'b0;
  int          n_tests = 0, n_fail = 0;

  task automatic add_pat(input logic [31:0] m, input logic [31:0] v, input int c, input logic [7:0] a);
    pm.push_back(m); pv.push_back(v); pcls.push_back(c); palu.push_back(a);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sx(input logic [63:0] v, input int n);
    logic signed [63:0] s;
    s = v << (64 - n);
    return 64'(s >>> (64 - n));
  endfunction

  function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc,
                                 input logic [63:0] a, input logic [63:0] b);
    exp_t e; int k; logic [63:0] pcx, iI, iS, iB, iU, iJ;
    e = '0; k = -1;
    for (int t = 0; t < pm.size(); t++) if ((i & pm[t]) == pv[t]) k = t;
    e.f3 = i[14:12]; e.rd = i[11:7];
    if (k < 0) begin e.invalid = 1'b1; return e; end
    pcx = 64'(pc);
    iI = sx(64'(i[31:20]), 12);
    iS = sx(64'({i[31:25], i[11:7]}), 12);
    iB = sx(64'({i[31], i[7], i[30:25], i[11:8], 1'b0}), 13);
    iU = sx(64'({i[31:12], 12'h000}), 32);
    iJ = sx(64'({i[31], i[19:12], i[20], i[30:21], 1'b0}), 21);
    e.alu = palu[k];
    case (pcls[k])
      C_R, C_RW:  begin e.op1 = a; e.op2 = b; e.we = 1; e.word = (pcls[k] == C_RW); end
      C_I, C_IW:  begin e.op1 = a; e.op2 = iI; e.we = 1; e.word = (pcls[k] == C_IW); end
      C_SH:       begin e.op1 = a; e.op2 = 64'(i[25:20]); e.we = 1; end
      C_SHW:      begin e.op1 = a; e.op2 = 64'(i[24:20]); e.we = 1; e.word = 1; end
      C_LD:       begin e.op1 = a; e.op2 = iI; e.we = 1; e.mrd = 1; end
      C_ST:       begin e.op1 = a; e.op2 = iS; e.mwr = 1; e.sd = b; end
      C_BR:       begin e.op1 = a; e.op2 = b; e.branch = 1; e.j1 = pc; e.j2 = iB[31:0]; end
      C_LUI:      begin e.op1 = 0; e.op2 = iU; e.we = 1; end
      C_AUIPC:    begin e.op1 = pcx; e.op2 = iU; e.we = 1; end
      C_JAL:      begin e.op1 = pcx; e.op2 = 4; e.we = 1; e.jump = 1; e.j1 = pc; e.j2 = iJ[31:0]; end
      C_JALR:     begin e.op1 = pcx; e.op2 = 4; e.we = 1; e.jump = 1; e.j1 = a[31:0]; e.j2 = iI[31:0]; end
      default:    e.ebreak = 1;
    endcase
    e.we = e.we && (e.rd != 0);
    return e;
  endfunction

  task automatic chk_head(input exp_t e);
    chk("invalid", out_invalid, e.invalid); chk("alu_op", out_alu_op, e.alu);
    chk("jump", out_jump, e.jump);          chk("branch", out_branch, e.branch);
    chk("mem_rd", out_mem_rd, e.mrd);       chk("mem_wr", out_mem_wr, e.mwr);
    chk("word", out_word, e.word);          chk("rd_we", out_rd_we, e.we);
    chk("ebreak", out_ebreak, e.ebreak);    chk("func3", out_func3, e.f3);
    if (!e.invalid && !e.ebreak) begin
      chk("op1", out_op1, e.op1); chk("op2", out_op2, e.op2); chk("rd", out_rd, e.rd);
      if (e.jump || e.branch) begin chk("jmp_op1", out_jmp_op1, e.j1); chk("jmp_op2", out_jmp_op2, e.j2); end
      if (e.mwr) chk("store_data", out_store_data, e.sd);
    end
  endtask

  task automatic tick();
    logic exp_rdy, push, pop; exp_t ne;
    @(negedge clk);
    exp_rdy = rdy_en && rst_n && (q.size() < DEPTH) && !flush;
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, q.size() != 0);
    chk("rs1_addr", rs1_addr, in_inst[19:15]);
    chk("rs2_addr", rs2_addr, in_inst[24:20]);
    if (q.size() != 0) chk_head(q[0]);
    push = in_valid && exp_rdy;
    pop  = (q.size() != 0) && out_ready;
    ne   = model(in_inst, in_pc, rs1_data, rs2_data);
    @(posedge clk); #1;
    if (rst_n) begin
      rdy_en = 1'b1;
      if (flush) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (push) q.push_back(ne);
      end
    end
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic [63:0] a);
    in_inst = inst; in_pc = pc; rs1_data = a; rs2_data = {$urandom, $urandom}; in_valid = 1'b1;
  endtask

  initial begin
    add_pat(32'h0000007F, 32'h00000037, C_LUI, 8'h01);  add_pat(32'h0000007F, 32'h00000017, C_AUIPC, 8'h01);
    add_pat(32'h0000007F, 32'h0000006F, C_JAL, 8'h01);  add_pat(32'h0000707F, 32'h00000067, C_JALR, 8'h01);
    for (int f = 0; f < 8; f++) if (f != 2 && f != 3) add_pat(32'h0000707F, 32'h63 | (f << 12), C_BR, 8'h02);
    for (int f = 0; f < 7; f++) add_pat(32'h0000707F, 32'h03 | (f << 12), C_LD, 8'h01);
    for (int f = 0; f < 4; f++) add_pat(32'h0000707F, 32'h23 | (f << 12), C_ST, 8'h01);
    add_pat(32'h0000707F, 32'h00000013, C_I, 8'h01);   add_pat(32'h0000707F, 32'h00002013, C_I, 8'h09);
    add_pat(32'h0000707F, 32'h00003013, C_I, 8'h0A);   add_pat(32'h0000707F, 32'h00004013, C_I, 8'h05);
    add_pat(32'h0000707F, 32'h00006013, C_I, 8'h04);   add_pat(32'h0000707F, 32'h00007013, C_I, 8'h03);
    add_pat(32'hFC00707F, 32'h00001013, C_SH, 8'h06);  add_pat(32'hFC00707F, 32'h00005013, C_SH, 8'h07);
    add_pat(32'hFC00707F, 32'h40005013, C_SH, 8'h08);
    add_pat(32'hFE00707F, 32'h00000033, C_R, 8'h01);   add_pat(32'hFE00707F, 32'h40000033, C_R, 8'h02);
    add_pat(32'hFE00707F, 32'h00001033, C_R, 8'h06);   add_pat(32'hFE00707F, 32'h00002033, C_R, 8'h09);
    add_pat(32'hFE00707F, 32'h00003033, C_R, 8'h0A);   add_pat(32'hFE00707F, 32'h00004033, C_R, 8'h05);
    add_pat(32'hFE00707F, 32'h00005033, C_R, 8'h07);   add_pat(32'hFE00707F, 32'h40005033, C_R, 8'h08);
    add_pat(32'hFE00707F, 32'h00006033, C_R, 8'h04);   add_pat(32'hFE00707F, 32'h00007033, C_R, 8'h03);
    add_pat(32'h0000707F, 32'h0000001B, C_IW, 8'h01);  add_pat(32'hFE00707F, 32'h0000101B, C_SHW, 8'h06);
    add_pat(32'hFE00707F, 32'h0000501B, C_SHW, 8'h07); add_pat(32'hFE00707F, 32'h4000501B, C_SHW, 8'h08);
    add_pat(32'hFE00707F, 32'h0000003B, C_RW, 8'h01);  add_pat(32'hFE00707F, 32'h4000003B, C_RW, 8'h02);
    add_pat(32'hFE00707F, 32'h0000103B, C_RW, 8'h06);  add_pat(32'hFE00707F, 32'h0000503B, C_RW, 8'h07);
    add_pat(32'hFE00707F, 32'h4000503B, C_RW, 8'h08);  add_pat(32'hFFFFFFFF, 32'h00100073, C_EBRK, 8'h00);

    // reset state
    #1;
    chk("rst_out_valid", out_valid, 0); chk("rst_in_ready", in_ready, 0);
    chk("rst_alu", out_alu_op, 0); chk("rst_op1", out_op1, 0); chk("rst_op2", out_op2, 0);
    chk("rst_rd", out_rd, 0); chk("rst_invalid", out_invalid, 0); chk("rst_jmp1", out_jmp_op1, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // addi x1,x0,5
    drive(32'h00500093, 32'h80000000, 64'd0); tick(); in_valid = 1'b0;
    chk("addi_valid", out_valid, 1); chk("addi_alu", out_alu_op, 8'h01); chk("addi_op1", out_op1, 0);
    chk("addi_op2", out_op2, 5); chk("addi_rd", out_rd, 1); chk("addi_we", out_rd_we, 1);
    out_ready = 1'b1; tick();

    // lui x2 then jal x1,+8
    drive(32'h12345137, 32'h80000000, 64'd7); tick();
    chk("lui_op2", out_op2, 64'h12345000);
    drive(32'h008000EF, 32'h80000004, 64'd9); tick(); in_valid = 1'b0;
    chk("jal_op1", out_op1, 64'h80000004); chk("jal_op2", out_op2, 4);
    chk("jal_j1", out_jmp_op1, 32'h80000004); chk("jal_j2", out_jmp_op2, 8); chk("jal_jump", out_jump, 1);
    tick();

    // back-pressure: fill, drain in order, simultaneous push/pop
    out_ready = 1'b0;
    drive(32'h00100093, 32'h100, 64'd1); tick();
    drive(32'h00200113, 32'h104, 64'd2); tick();
    drive(32'h00300193, 32'h108, 64'd3); tick();
    chk("full_ready", in_ready, 0);
    in_valid = 1'b0; out_ready = 1'b1; tick();
    chk("order_rd", out_rd, 2);
    in_valid = 1'b1; tick();
    chk("pushpop_valid", out_valid, 1); chk("pushpop_ready", in_ready, 1); chk("pushpop_rd", out_rd, 3);
    in_valid = 1'b0; tick();

    // invalid encodings and ebreak
    drive(32'hFFFFFFFF, 32'h200, 64'd0); tick();
    chk("ff_invalid", out_invalid, 1); chk("ff_we", out_rd_we, 0);
    drive(32'h00000000, 32'h204, 64'd0); tick();
    chk("zero_invalid", out_invalid, 1); chk("zero_alu", out_alu_op, 0);
    drive(32'h00100073, 32'h208, 64'd0); tick();
    chk("ebreak", out_ebreak, 1); chk("ebreak_invalid", out_invalid, 0);
    in_valid = 1'b0; tick();

    // flush with a full queue and a pending input
    out_ready = 1'b0;
    drive(32'h00400213, 32'h300, 64'd0); tick();
    drive(32'h00500293, 32'h304, 64'd0); tick();
    flush = 1'b1; drive(32'h00600313, 32'h308, 64'd0); tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", out_valid, 0);
    out_ready = 1'b1; repeat (3) tick();

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    drive(32'h00100393, 32'h400, 64'd0); tick(); in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1 chk("async_valid", out_valid, 0); chk("async_alu", out_alu_op, 0);
    q.delete(); rdy_en = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1; tick();
    drive(32'h00700293, 32'h500, 64'd0); tick(); in_valid = 1'b0;
    chk("post_rst_valid", out_valid, 1); chk("post_rst_op2", out_op2, 7); chk("post_rst_rd", out_rd, 5);
    out_ready = 1'b1; tick();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      int t;
      logic [31:0] inst;
      t = $urandom_range(0, pm.size() - 1);
      if ($urandom_range(0, 9) == 0) inst = $urandom;
      else inst = ($urandom & ~pm[t]) | pv[t];
      drive(inst, $urandom & 32'hFFFFFFFC, {$urandom, $urandom});
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 29) == 0);
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
